// File: rtl/cpsd_pkg.sv
// Shared CPSD datapath definitions: serializer state encoding, default sample width
// and a clog2 helper that never returns less than one bit.
package cpsd_pkg;

  typedef enum logic {
    StIdle  = 1'b0,
    StShift = 1'b1
  } state_e;

  localparam int unsigned DefaultDataWidth = 16;

  // A single-word frame still needs a 1-bit counter.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/frame_serializer_if.sv
// Frame-in / word-out handshake bundle for frame_serializer.
// The serializer uses the slave modport; the driving environment uses master.
interface frame_serializer_if #(
  parameter int unsigned DATA_WIDTH  = cpsd_pkg::DefaultDataWidth,
  parameter int unsigned NB_OF_WORDS = 8
);

  logic                              in_valid;
  logic                              in_ready;
  logic [DATA_WIDTH*NB_OF_WORDS-1:0] xin;
  logic                              out_valid;
  logic                              out_ready;
  logic [DATA_WIDTH-1:0]             y;
  logic                              out_last;

  modport master (
    output in_valid,
    output xin,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  y,
    input  out_last
  );

  modport slave (
    input  in_valid,
    input  xin,
    input  out_ready,
    output in_ready,
    output out_valid,
    output y,
    output out_last
  );

endinterface

// File: rtl/frame_serializer.sv
// Parallel-in, serial-out frame unloader: one frame per handshake, one word per beat.
// Define FRAME_SERIALIZER_REVERSE_EN to emit words in descending index order.
module frame_serializer
  import cpsd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DefaultDataWidth,
  parameter int unsigned NB_OF_WORDS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  frame_serializer_if.slave  bus,
  output logic               busy
);

  localparam int unsigned          CNT_WIDTH = clog2_min1(NB_OF_WORDS);
  localparam logic [CNT_WIDTH-1:0] LastCnt   = CNT_WIDTH'(NB_OF_WORDS - 1);

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]  sel_idx;
  logic [DATA_WIDTH-1:0] frame_q [NB_OF_WORDS];
  logic [DATA_WIDTH-1:0] frame_d [NB_OF_WORDS];
  logic                  cnt_last;
  logic                  beat;
  logic                  load;

  always_comb begin
    cnt_last      = (cnt_q == LastCnt);
    state_d       = state_q;
    cnt_d         = cnt_q;
    frame_d       = frame_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    beat          = 1'b0;

    if (!rst && en) begin
      unique case (state_q)
        StIdle: begin
          bus.in_ready = 1'b1;
        end
        StShift: begin
          bus.out_valid = 1'b1;
          bus.out_last  = cnt_last;
          // out_ready -> in_ready lets the next frame load on the final beat.
          bus.in_ready  = cnt_last & bus.out_ready;
          beat          = bus.out_ready;
        end
        default: ;
      endcase
    end

    load = bus.in_valid & bus.in_ready;

    if (load) begin
      state_d = StShift;
      cnt_d   = '0;
      for (int unsigned k = 0; k < NB_OF_WORDS; k++) begin
        frame_d[k] = bus.xin[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end else if (beat) begin
      if (cnt_last) begin
        state_d = StIdle;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      for (int unsigned k = 0; k < NB_OF_WORDS; k++) begin
        frame_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
    end
  end

`ifdef FRAME_SERIALIZER_REVERSE_EN
  assign sel_idx = LastCnt - cnt_q;
`else
  assign sel_idx = cnt_q;
`endif

  // y is selected from registered state only; xin never reaches it combinationally.
  assign bus.y = frame_q[sel_idx];
  assign busy  = (state_q == StShift);

endmodule

// File: tb/tb_frame_serializer.sv
// Directed bench for frame_serializer: a 4-word instance and a 1-word instance.
// Expected word order follows FRAME_SERIALIZER_REVERSE_EN when it is defined.
module tb_frame_serializer;

  localparam logic [63:0] FRAME_A = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
  localparam logic [63:0] FRAME_B = {16'h0014, 16'h0013, 16'h0012, 16'h0011};

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic busy4;
  logic busy1;

  int n_vec = 0;
  int n_err = 0;

  frame_serializer_if #(.DATA_WIDTH(16), .NB_OF_WORDS(4)) if4 ();
  frame_serializer_if #(.DATA_WIDTH(16), .NB_OF_WORDS(1)) if1 ();

  frame_serializer #(.DATA_WIDTH(16), .NB_OF_WORDS(4)) dut4 (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .bus  (if4.slave),
    .busy (busy4)
  );

  frame_serializer #(.DATA_WIDTH(16), .NB_OF_WORDS(1)) dut1 (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .bus  (if1.slave),
    .busy (busy1)
  );

  always #5 clk = ~clk;

  // m-th emitted word of a 4-word frame.
  function automatic logic [15:0] exp_word(input logic [63:0] f, input int m);
    int idx;
`ifdef FRAME_SERIALIZER_REVERSE_EN
    idx = 3 - m;
`else
    idx = m;
`endif
    return f[idx*16 +: 16];
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic load4(input logic [63:0] f);
    if4.in_valid = 1'b1;
    if4.xin      = f;
    @(negedge clk);
    n_vec++;
    if (if4.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL load_in_ready: got %b want 1", if4.in_ready);
    end
    next_cycle();
    if4.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [19:0] got;
    rst = 1'b1;
    en  = 1'b1;
    if4.in_valid = 1'b0; if4.xin = '0; if4.out_ready = 1'b1;
    if1.in_valid = 1'b0; if1.xin = '0; if1.out_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    got = {16'h0, if4.in_ready, if4.out_valid, if1.in_ready, if1.out_valid};
    if (got !== 20'h0) begin
      n_err++;
      $display("FAIL reset_gating: got %h want 00000", got);
    end
    next_cycle();
    @(negedge clk);
    n_vec++;
    got = {if4.y, if4.out_valid, if4.out_last, busy4, busy1};
    if (got !== 20'h0) begin
      n_err++;
      $display("FAIL reset_state: got %h want 00000", got);
    end
    n_vec++;
    if (if1.y !== 16'h0) begin
      n_err++;
      $display("FAIL reset_y1: got %h want 0000", if1.y);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if ({if4.in_ready, if1.in_ready} !== 2'b11) begin
      n_err++;
      $display("FAIL idle_in_ready: got %b want 11", {if4.in_ready, if1.in_ready});
    end
    next_cycle();
  endtask

  task automatic test_single_frame();
    logic [18:0] got, want;
    if4.out_ready = 1'b1;
    load4(FRAME_A);
    for (int m = 0; m < 4; m++) begin
      @(negedge clk);
      got  = {if4.out_valid, if4.out_last, busy4, if4.y};
      want = {1'b1, (m == 3), 1'b1, exp_word(FRAME_A, m)};
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL single_frame[%0d]: got %h want %h", m, got, want);
      end
      next_cycle();
    end
    @(negedge clk);
    n_vec++;
    if ({if4.out_valid, busy4} !== 2'b00) begin
      n_err++;
      $display("FAIL single_frame_done: got %b want 00", {if4.out_valid, busy4});
    end
    next_cycle();
  endtask

  task automatic test_backpressure();
    logic [15:0] pat = 16'b0000_0011_0110_1001;
    logic [18:0] got, want;
    int m = 0;
    load4(FRAME_A);
    for (int c = 0; c < 16 && m < 4; c++) begin
      if4.out_ready = pat[c];
      @(negedge clk);
      got  = {if4.out_valid, if4.out_last, if4.in_ready, exp_word(FRAME_A, m) ^ if4.y};
      want = {1'b1, (m == 3), (m == 3) && pat[c], 16'h0};
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL backpressure[c%0d m%0d]: got %h y=%h want %h y=%h",
                 c, m, got, if4.y, want, exp_word(FRAME_A, m));
      end
      if (pat[c]) m++;
      next_cycle();
    end
    n_vec++;
    if (m != 4) begin
      n_err++;
      $display("FAIL backpressure_beats: got %0d want 4", m);
    end
    if4.out_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (busy4 !== 1'b0) begin
      n_err++;
      $display("FAIL backpressure_done: got busy %b want 0", busy4);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic [18:0] got, want;
    if4.out_ready = 1'b1;
    load4(FRAME_A);
    if4.in_valid = 1'b1;
    if4.xin      = FRAME_B;
    for (int m = 0; m < 4; m++) begin
      @(negedge clk);
      got  = {if4.in_ready, if4.out_valid, if4.out_last, if4.y};
      want = {(m == 3), 1'b1, (m == 3), exp_word(FRAME_A, m)};
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL b2b_first[%0d]: got %h want %h", m, got, want);
      end
      next_cycle();
    end
    if4.in_valid = 1'b0;
    for (int m = 0; m < 4; m++) begin
      @(negedge clk);
      got  = {if4.in_ready, if4.out_valid, if4.out_last, if4.y};
      want = {(m == 3), 1'b1, (m == 3), exp_word(FRAME_B, m)};
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL b2b_second[%0d]: got %h want %h", m, got, want);
      end
      next_cycle();
    end
    @(negedge clk);
    n_vec++;
    if (busy4 !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_done: got busy %b want 0", busy4);
    end
    next_cycle();
  endtask

  task automatic test_en_drop();
    logic [19:0] got, want;
    if4.out_ready = 1'b1;
    load4(FRAME_A);
    for (int m = 0; m < 4; m++) begin
      if (m == 2) begin
        en           = 1'b0;
        if4.in_valid = 1'b1;
        if4.xin      = FRAME_B;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          got  = {if4.out_valid, if4.in_ready, if4.out_last, busy4, if4.y};
          want = {4'b0001, exp_word(FRAME_A, 2)};
          n_vec++;
          if (got !== want) begin
            n_err++;
            $display("FAIL en_low[%0d]: got %h want %h", c, got, want);
          end
          next_cycle();
        end
        en           = 1'b1;
        if4.in_valid = 1'b0;
      end
      @(negedge clk);
      got  = {1'b0, if4.out_valid, if4.out_last, busy4, if4.y};
      want = {1'b0, 1'b1, (m == 3), 1'b1, exp_word(FRAME_A, m)};
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL en_drop[%0d]: got %h want %h", m, got, want);
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [17:0] got, want;
    if4.out_ready = 1'b1;
    load4(FRAME_A);
    next_cycle();
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({if4.out_valid, if4.in_ready} !== 2'b00) begin
      n_err++;
      $display("FAIL rst_mid_gating: got %b want 00", {if4.out_valid, if4.in_ready});
    end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({if4.out_valid, busy4, if4.y} !== 18'h0) begin
      n_err++;
      $display("FAIL rst_mid_state: got %h want 00000", {if4.out_valid, busy4, if4.y});
    end
    next_cycle();
    load4(FRAME_B);
    for (int m = 0; m < 4; m++) begin
      @(negedge clk);
      got  = {if4.out_valid, if4.out_last, if4.y};
      want = {1'b1, (m == 3), exp_word(FRAME_B, m)};
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL rst_mid_next[%0d]: got %h want %h", m, got, want);
      end
      next_cycle();
    end
  endtask

  task automatic test_single_word();
    logic [18:0] got;
    if1.out_ready = 1'b1;
    if1.in_valid  = 1'b1;
    if1.xin       = 16'h00AB;
    @(negedge clk);
    n_vec++;
    if (if1.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL n1_load: got %b want 1", if1.in_ready);
    end
    next_cycle();
    if1.xin = 16'h00CD;
    @(negedge clk);
    got = {if1.out_valid, if1.out_last, if1.in_ready, if1.y};
    n_vec++;
    if (got !== {3'b111, 16'h00AB}) begin
      n_err++;
      $display("FAIL n1_first: got %h want 700ab", got);
    end
    next_cycle();
    if1.in_valid = 1'b0;
    @(negedge clk);
    got = {if1.out_valid, if1.out_last, busy1, if1.y};
    n_vec++;
    if (got !== {3'b111, 16'h00CD}) begin
      n_err++;
      $display("FAIL n1_second: got %h want 700cd", got);
    end
    next_cycle();
    @(negedge clk);
    n_vec++;
    if ({if1.out_valid, if1.out_last, busy1} !== 3'b000) begin
      n_err++;
      $display("FAIL n1_done: got %b want 000", {if1.out_valid, if1.out_last, busy1});
    end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_back_to_back();
    test_en_drop();
    test_reset_mid_frame();
    test_single_word();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "bench timed out");
  end

endmodule
